// File: rtl/pe_acc_array.sv
// pe_acc_array: LANES-wide signed multiply / adder-tree / accumulate engine.
// A group of acc_len input vectors is reduced to one dot-product result.
// Pipeline: multiply -> log2(LANES) pairwise adder stages -> accumulate -> output.
// Any pending unaccepted result stalls every stage; there is no input buffering.
module pe_acc_array #(
  parameter int LANES = 16,
  parameter int IFM_W = 8,
  parameter int KER_W = 16,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*IFM_W-1:0]   ifm_in,
  input  logic [LANES*KER_W-1:0]   kernel_in,
  input  logic                     mode,
  input  logic [CNT_W-1:0]         acc_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         dout,
  output logic                     busy
);

  localparam int LVLS   = $clog2(LANES);
  localparam int HALF_W = KER_W / 2;
  // A full-width product bounds the packed-mode sum of two half products.
  localparam int PROD_W = KER_W + IFM_W;
  localparam int TREE_W = PROD_W + LVLS;

  // Lane product: full kernel times activation, or the sum of both
  // half-kernel products when packed mode is selected.
  function automatic logic signed [PROD_W-1:0] lane_mul(
    input logic signed [IFM_W-1:0] a,
    input logic        [KER_W-1:0] k,
    input logic                    packed_mode
  );
    logic signed [KER_W-1:0]  kf;
    logic signed [HALF_W-1:0] kh;
    logic signed [HALF_W-1:0] kl;
    logic signed [PROD_W-1:0] pf;
    logic signed [PROD_W-1:0] ph;
    logic signed [PROD_W-1:0] pl;
    kf = k;
    kh = k[KER_W-1:HALF_W];
    kl = k[HALF_W-1:0];
    pf = PROD_W'(kf) * PROD_W'(a);
    ph = PROD_W'(kh) * PROD_W'(a);
    pl = PROD_W'(kl) * PROD_W'(a);
    return packed_mode ? (ph + pl) : pf;
  endfunction

  // Tree sum to accumulator width: sign-extend when narrower, wrap when wider.
  function automatic logic signed [ACC_W-1:0] fit_acc(
    input logic signed [TREE_W-1:0] v
  );
    return ACC_W'(v);
  endfunction

  logic             advance;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic             mode_q;
  logic             first_beat;
  logic             last_beat;
  logic             mode_eff;
  logic [CNT_W:0]   cnt_inc;
  logic [LVLS:0]    stage_vld;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // Group position of the beat on the inputs; the first beat uses live mode/acc_len.
  always_comb begin
    first_beat = (cnt == '0);
    mode_eff   = first_beat ? mode : mode_q;
    cnt_inc    = {1'b0, cnt} + (CNT_W+1)'(1);
    if (first_beat) last_beat = (acc_len <= CNT_W'(1));
    else            last_beat = (cnt_inc == {1'b0, len_q});
  end

  // Beat counter with group settings latched on the first beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      len_q  <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      if (first_beat) begin
        mode_q <= mode;
        len_q  <= (acc_len == '0) ? CNT_W'(1) : acc_len;
        cnt    <= last_beat ? '0 : CNT_W'(1);
      end else begin
        cnt    <= last_beat ? '0 : cnt_inc[CNT_W-1:0];
      end
    end
  end

  for (genvar k = 0; k <= LVLS; k++) begin : stg
    localparam int W = PROD_W + k;
    localparam int N = LANES >> k;
    logic signed [W-1:0] sum_p [N];
    logic                vld_p;
    logic                first_p;
    logic                last_p;

    assign stage_vld[k] = vld_p;

    if (k == 0) begin : g_mul
      // ---- stage p0: lane multiply ----
      // Control flags for the multiply stage.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p   <= 1'b0;
          first_p <= 1'b0;
          last_p  <= 1'b0;
        end else if (advance) begin
          vld_p   <= accept;
          first_p <= first_beat;
          last_p  <= last_beat;
        end
      end

      // Registered lane products.
      always_ff @(posedge clk) begin
        if (accept) begin
          for (int i = 0; i < LANES; i++) begin
            sum_p[i] <= lane_mul(ifm_in[i*IFM_W +: IFM_W],
                                 kernel_in[i*KER_W +: KER_W], mode_eff);
          end
        end
      end
    end else begin : g_add
      // ---- stage p<k>: pairwise add, one bit wider than the stage before ----
      // Control flags follow the data down the tree.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p   <= 1'b0;
          first_p <= 1'b0;
          last_p  <= 1'b0;
        end else if (advance) begin
          vld_p   <= stg[k-1].vld_p;
          first_p <= stg[k-1].first_p;
          last_p  <= stg[k-1].last_p;
        end
      end

      // Sum lanes 2j and 2j+1 of the previous stage.
      always_ff @(posedge clk) begin
        if (advance && stg[k-1].vld_p) begin
          for (int j = 0; j < N; j++) begin
            sum_p[j] <= W'(stg[k-1].sum_p[2*j]) + W'(stg[k-1].sum_p[2*j+1]);
          end
        end
      end
    end
  end

  logic signed [ACC_W-1:0] tree_fit;
  logic signed [ACC_W-1:0] acc_pa;
  logic                    vld_pa;
  logic                    last_pa;

  assign tree_fit = fit_acc(stg[LVLS].sum_p[0]);

  // ---- accumulate stage: first beat loads, later beats add with wrap ----
  // Accumulator and its flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pa  <= 1'b0;
      last_pa <= 1'b0;
      acc_pa  <= '0;
    end else if (advance) begin
      vld_pa  <= stg[LVLS].vld_p;
      last_pa <= stg[LVLS].last_p;
      if (stg[LVLS].vld_p) begin
        acc_pa <= stg[LVLS].first_p ? tree_fit : (acc_pa + tree_fit);
      end
    end
  end

  // ---- output stage: result held until taken ----
  // Publish a completed group and hold it while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (advance) begin
      out_valid <= vld_pa && last_pa;
      if (vld_pa && last_pa) dout <= acc_pa;
    end
  end

  assign busy = (|stage_vld) || vld_pa || (cnt != '0);

endmodule

// File: tb/tb_pe_acc_array.sv
// Directed bench for pe_acc_array: a 32-bit and a 16-bit accumulator
// instance share one stimulus stream; results are collected on handshake.
module tb_pe_acc_array;
  localparam int LANES = 16;
  localparam int IFM_W = 8;
  localparam int KER_W = 16;
  localparam int CNT_W = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   mode;
  logic                   out_ready;
  logic [LANES*IFM_W-1:0] ifm_in;
  logic [LANES*KER_W-1:0] kernel_in;
  logic [CNT_W-1:0]       acc_len;
  logic                   in_ready, out_valid, busy;
  logic [31:0]            dout;
  logic                   in_ready16, out_valid16, busy16;
  logic [15:0]            dout16;

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] got_q[$];
  logic [15:0] got16_q[$];

  pe_acc_array #(.LANES(LANES), .IFM_W(IFM_W), .KER_W(KER_W), .ACC_W(32), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ifm_in(ifm_in), .kernel_in(kernel_in), .mode(mode), .acc_len(acc_len),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy));

  pe_acc_array #(.LANES(LANES), .IFM_W(IFM_W), .KER_W(KER_W), .ACC_W(16), .CNT_W(CNT_W)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16),
    .ifm_in(ifm_in), .kernel_in(kernel_in), .mode(mode), .acc_len(acc_len),
    .out_valid(out_valid16), .out_ready(out_ready), .dout(dout16), .busy(busy16));

  always #5 clk = ~clk;

  // Record every result that will be taken at the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready)     got_q.push_back(dout);
    if (!reset && out_valid16 && out_ready)   got16_q.push_back(dout16);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [IFM_W-1:0] a, input logic [KER_W-1:0] k,
                          input logic m, input logic [CNT_W-1:0] len);
    for (int i = 0; i < LANES; i++) begin
      ifm_in[i*IFM_W +: IFM_W]    = a;
      kernel_in[i*KER_W +: KER_W] = k;
    end
    mode    = m;
    acc_len = len;
  endtask

  // Present one beat and return just after the edge that accepts it.
  task automatic send_beat(input logic [IFM_W-1:0] a, input logic [KER_W-1:0] k,
                           input logic m, input logic [CNT_W-1:0] len);
    logic rdy;
    int   guard;
    set_beat(a, k, m, len);
    in_valid = 1'b1;
    rdy      = 1'b0;
    guard    = 0;
    while (!rdy && guard < 60) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!rdy) check("accept_timeout", rdy, 1'b1);
  endtask

  task automatic wait_results(input int n, input int budget);
    int g;
    g = 0;
    while (got_q.size() < n && g < budget) begin
      tick();
      g++;
    end
    check("results_ready", got_q.size(), n);
  endtask

  task automatic expect_result(input string tag, input logic [31:0] exp);
    check({tag, "_avail"}, (got_q.size() > 0 && got16_q.size() > 0), 1'b1);
    if (got_q.size() > 0)   check(tag, got_q.pop_front(), exp);
    if (got16_q.size() > 0) check({tag, "_acc16"}, got16_q.pop_front(), exp[15:0]);
  endtask

  int          lat, pulses, g2;
  logic [31:0] d0;
  logic        ready_low, held;

  initial begin
    reset = 1'b1; in_valid = 1'b0; mode = 1'b0; acc_len = '0; out_ready = 1'b1;
    ifm_in = '0; kernel_in = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_dout", dout, 32'h0);

    // Single-beat group, latency and pulse width.
    send_beat(8'd1, 16'd2, 1'b0, 8'd1);
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    lat = 0; pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (out_valid) begin
        if (lat == 0) lat = i;
        pulses++;
      end
    end
    check("latency", lat, 6);
    check("pulse_len", pulses, 1);
    expect_result("sum_ones", 32'd32);

    // Packed-kernel mode with negative activation.
    send_beat(8'hFD, 16'h02FF, 1'b1, 8'd1);
    in_valid = 1'b0;
    wait_results(1, 20);
    expect_result("packed_mode", 32'hFFFF_FFD0);

    // Four-beat group; mode/acc_len wiggle after the first beat.
    send_beat(8'd1, 16'd1, 1'b0, 8'd4);
    send_beat(8'd1, 16'd2, 1'b1, 8'd1);
    send_beat(8'd1, 16'd3, 1'b1, 8'd0);
    send_beat(8'd1, 16'd4, 1'b0, 8'd2);
    in_valid = 1'b0;
    wait_results(1, 20);
    expect_result("acc4", 32'd160);
    repeat (10) tick();
    check("acc4_single", got_q.size(), 0);

    // Mode latched on first beat: second beat asks for packed mode.
    send_beat(8'd1, 16'h0100, 1'b0, 8'd2);
    send_beat(8'd1, 16'h0100, 1'b1, 8'd1);
    in_valid = 1'b0;
    wait_results(1, 20);
    expect_result("mode_latch", 32'd8192);

    // Back-to-back groups without bubbles, acc_len=0 treated as 1.
    send_beat(8'd1, 16'd1, 1'b0, 8'd1);
    send_beat(8'd1, 16'd2, 1'b0, 8'd0);
    send_beat(8'd1, 16'd3, 1'b0, 8'd1);
    send_beat(8'd2, 16'd3, 1'b0, 8'd2);
    send_beat(8'd1, 16'd1, 1'b0, 8'd2);
    in_valid = 1'b0;
    wait_results(4, 30);
    expect_result("b2b_0", 32'd16);
    expect_result("b2b_1", 32'd32);
    expect_result("b2b_2", 32'd48);
    expect_result("b2b_3", 32'd112);

    // Backpressure with beats streaming.
    fork
      begin
        for (int k = 5; k <= 12; k++) send_beat(8'd1, KER_W'(k), 1'b0, 8'd1);
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        g2 = 0;
        while (!out_valid && g2 < 30) begin
          tick();
          g2++;
        end
        check("stall_seen", out_valid, 1'b1);
        d0 = dout;
        ready_low = 1'b1;
        held = 1'b1;
        repeat (5) begin
          tick();
          if (in_ready) ready_low = 1'b0;
          if (dout !== d0 || !out_valid) held = 1'b0;
        end
        check("stall_ready_low", ready_low, 1'b1);
        check("stall_dout_hold", held, 1'b1);
        check("stall_dout", d0, 32'd80);
        out_ready = 1'b1;
      end
    join
    wait_results(8, 40);
    for (int i = 0; i < 8; i++) expect_result("stall_order", 32'(80 + 16*i));

    // Reset in the middle of a four-beat group.
    send_beat(8'd1, 16'd1, 1'b0, 8'd4);
    send_beat(8'd1, 16'd1, 1'b0, 8'd4);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_dout", dout, 32'h0);
    repeat (12) tick();
    check("midrst_no_result", got_q.size(), 0);
    send_beat(8'd1, 16'd1, 1'b0, 8'd1);
    in_valid = 1'b0;
    wait_results(1, 20);
    expect_result("after_reset", 32'd16);

    // Large operands: 16-bit accumulator wraps, 32-bit holds the true sum.
    send_beat(8'd127, 16'h7FFF, 1'b0, 8'd1);
    in_valid = 1'b0;
    wait_results(1, 20);
    expect_result("wrap", 32'h03F7_F810);

    repeat (3) tick();
    check("end_busy", busy, 1'b0);
    check("end_out_valid", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
